// File: rtl/fpu_ctrl_pkg.sv
// Shared constants for the FPU operation sequencing controllers:
// state encoding, RISC-V rounding-mode codes and flag bit positions.
package fpu_ctrl_pkg;

  // Controller state encoding (3 bits)
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_RMUL = 3'd2;
  localparam logic [2:0] ST_ADD  = 3'd3;
  localparam logic [2:0] ST_RADD = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_MUL  = ST_MUL,
    S_RMUL = ST_RMUL,
    S_ADD  = ST_ADD,
    S_RADD = ST_RADD,
    S_DONE = ST_DONE
  } state_e;

  // RISC-V rounding modes
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  // fflags bit positions {NV,DZ,OF,UF,NX}
  localparam int FF_NX = 0;
  localparam int FF_UF = 1;
  localparam int FF_OF = 2;
  localparam int FF_DZ = 3;
  localparam int FF_NV = 4;

  // Rounding-stage status bit positions {OF,UF,NX}
  localparam int SF_NX = 0;
  localparam int SF_UF = 1;
  localparam int SF_OF = 2;

endpackage

// File: rtl/fpu_rm_resolve.sv
// Rounding-mode resolution shared by the FPU op controllers: picks the
// CSR frm for dynamic rounding and flags reserved encodings as illegal.
module fpu_rm_resolve
  import fpu_ctrl_pkg::*;
(
  input  logic [2:0] in_rm,
  input  logic [2:0] frm_csr,
  output logic [2:0] rm_eff,
  output logic       legal
);

  // Select effective mode and check it against the defined encodings
  always_comb begin
    rm_eff = (in_rm == RM_DYN) ? frm_csr : in_rm;
    legal  = 1'b0;
    case (rm_eff)
      RM_RNE, RM_RTZ, RM_RDN, RM_RUP, RM_RMM: legal = 1'b1;
      default:                                legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/fmadd_seq_ctrl.sv
// Sequencing controller for the multi-cycle BF16/FP32 fused multiply-add
// datapath: accepts one op, steps multiply / mul-round / add / add-round,
// accumulates rounding status into fflags and holds the result until taken.
module fmadd_seq_ctrl
  import fpu_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int ADD_LAT = 2,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_rm,
  input  logic [2:0] frm_csr,
  input  logic       flush,
  output logic       dp_mul_start,
  output logic [2:0] dp_rm,
  output logic       dp_mul_rnd_cap,
  output logic       dp_add_start,
  output logic       dp_add_rnd_cap,
  input  logic [2:0] dp_mul_sflags,
  input  logic [2:0] dp_add_sflags,
  input  logic       dp_nv,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_fflags,
  output logic       out_illegal,
  output logic       busy
);

  localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] ADD_CNT_INIT = CNT_W'(ADD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       rm_q, rm_d;
  logic             illegal_q, illegal_d;
  logic             nv_q, nv_d;
  logic             of_m_q, of_m_d;
  logic             nx_m_q, nx_m_d;
  logic             of_a_q, of_a_d;
  logic             uf_a_q, uf_a_d;
  logic             nx_a_q, nx_a_d;

  logic [2:0]       rm_eff;
  logic             rm_legal;
  logic             accept;

  fpu_rm_resolve u_rm_resolve (
    .in_rm   (in_rm),
    .frm_csr (frm_csr),
    .rm_eff  (rm_eff),
    .legal   (rm_legal)
  );

  assign dp_rm     = rm_q;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);

  // Handshake, next-state, flag accumulation and datapath pulses
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rm_d           = rm_q;
    illegal_d      = illegal_q;
    nv_d           = nv_q;
    of_m_d         = of_m_q;
    nx_m_d         = nx_m_q;
    of_a_d         = of_a_q;
    uf_a_d         = uf_a_q;
    nx_a_d         = nx_a_q;
    dp_mul_start   = 1'b0;
    dp_mul_rnd_cap = 1'b0;
    dp_add_start   = 1'b0;
    dp_add_rnd_cap = 1'b0;
    out_fflags     = '0;
    out_illegal    = 1'b0;

    // flush blocks a same-cycle accept so the aborted slot stays empty
    in_ready = ~flush & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
    accept   = in_valid & in_ready;

    if (state_q == S_DONE) begin
      out_fflags[FF_NV] = nv_q;
      out_fflags[FF_DZ] = 1'b0;
      out_fflags[FF_OF] = of_m_q | of_a_q;
      out_fflags[FF_UF] = uf_a_q;
      // a product that overflowed to the rounded limit is necessarily inexact
      out_fflags[FF_NX] = nx_m_q | nx_a_q | of_m_q;
      out_illegal       = illegal_q;
    end

    if (flush) begin
      state_d   = S_IDLE;
      illegal_d = 1'b0;
      nv_d      = 1'b0;
      of_m_d    = 1'b0;
      nx_m_d    = 1'b0;
      of_a_d    = 1'b0;
      uf_a_d    = 1'b0;
      nx_a_d    = 1'b0;
    end else begin
      case (state_q)
        S_MUL: begin
          if (cnt_q == '0) state_d = S_RMUL;
          else             cnt_d   = cnt_q - CNT_ONE;
        end
        S_RMUL: begin
          // product UF is only intermediate; the final add decides underflow
          dp_mul_rnd_cap = 1'b1;
          dp_add_start   = 1'b1;
          of_m_d         = dp_mul_sflags[SF_OF];
          nx_m_d         = dp_mul_sflags[SF_NX];
          nv_d           = dp_nv;
          cnt_d          = ADD_CNT_INIT;
          state_d        = S_ADD;
        end
        S_ADD: begin
          if (cnt_q == '0) state_d = S_RADD;
          else             cnt_d   = cnt_q - CNT_ONE;
        end
        S_RADD: begin
          dp_add_rnd_cap = 1'b1;
          of_a_d         = dp_add_sflags[SF_OF];
          uf_a_d         = dp_add_sflags[SF_UF];
          nx_a_d         = dp_add_sflags[SF_NX];
          state_d        = S_DONE;
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: ;
      endcase

      // accept only happens in IDLE or DONE, so it overrides the case above
      if (accept) begin
        nv_d   = 1'b0;
        of_m_d = 1'b0;
        nx_m_d = 1'b0;
        of_a_d = 1'b0;
        uf_a_d = 1'b0;
        nx_a_d = 1'b0;
        if (rm_legal) begin
          rm_d         = rm_eff;
          illegal_d    = 1'b0;
          dp_mul_start = 1'b1;
          cnt_d        = MUL_CNT_INIT;
          state_d      = S_MUL;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_DONE;
        end
      end
    end
  end

  // State, counter and accumulated status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rm_q      <= '0;
      illegal_q <= 1'b0;
      nv_q      <= 1'b0;
      of_m_q    <= 1'b0;
      nx_m_q    <= 1'b0;
      of_a_q    <= 1'b0;
      uf_a_q    <= 1'b0;
      nx_a_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rm_q      <= rm_d;
      illegal_q <= illegal_d;
      nv_q      <= nv_d;
      of_m_q    <= of_m_d;
      nx_m_q    <= nx_m_d;
      of_a_q    <= of_a_d;
      uf_a_q    <= uf_a_d;
      nx_a_q    <= nx_a_d;
    end
  end

endmodule

// File: doc/fmadd_seq_ctrl.md
Name: fmadd_seq_ctrl

Overview:
Sequencing controller for the multi-cycle BF16/FP32 fused multiply-add datapath. It accepts one operation at a time over a valid/ready handshake and resolves the rounding mode. It then steps the datapath through four phases: multiply, multiplication rounding, addition and addition rounding. Sticky status flags from both rounding stages are accumulated into RISC-V fflags, and the result is presented under a valid/ready handshake with backpressure.

Parameters:
MUL_LAT, 2, cycles the multiplier/normaliser needs before the multiplication-rounding stage output is valid (>=1)
ADD_LAT, 2, cycles the aligner/adder/normaliser needs before the addition-rounding stage output is valid (>=1)
CNT_W, 4, width of the phase counter; must satisfy 2^CNT_W > max(MUL_LAT, ADD_LAT)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  operation request
in_ready  out  1  controller can accept a request
in_rm  in  3  instruction rounding mode (111 = dynamic)
frm_csr  in  3  CSR frm, used when in_rm = 111
flush  in  1  synchronous abort of the current operation
dp_mul_start  out  1  one-cycle pulse: datapath latches operands and starts multiply
dp_rm  out  3  resolved rounding mode, held stable from accept until return to IDLE
dp_mul_rnd_cap  out  1  one-cycle pulse: capture multiplication-rounding result and flags
dp_add_start  out  1  one-cycle pulse: start addition using the captured product
dp_add_rnd_cap  out  1  one-cycle pulse: capture final rounded result
dp_mul_sflags  in  3  {OF,UF,NX} from multiplication rounding stage
dp_add_sflags  in  3  {OF,UF,NX} from addition rounding stage
dp_nv  in  1  invalid-operation indication from special-case detection
out_valid  out  1  result and flags valid
out_ready  in  1  consumer accepts the result
out_fflags  out  5  {NV,DZ,OF,UF,NX}
out_illegal  out  1  rounding mode was illegal; the result must be discarded
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, MUL, RMUL, ADD, RADD, DONE. Reset puts the FSM in IDLE, and every output is 0 except in_ready, which is 1.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Accept occurs when in_valid & in_ready.
- On accept:
  - rm_eff = (in_rm==111) ? frm_csr : in_rm.
  - rm_eff is legal only in {000,001,010,011,100}.
  - Legal: latch dp_rm, pulse dp_mul_start in the accept cycle, load counter = MUL_LAT-1, go to MUL.
  - Illegal: latch out_illegal=1, fflags=0, go directly to DONE; no datapath pulses are issued.
- MUL: decrement the counter each cycle; at 0 go to RMUL. The FSM spends exactly MUL_LAT cycles in MUL.
- RMUL (1 cycle):
  - Pulse dp_mul_rnd_cap.
  - Sample OF_m, NX_m, and NV from dp_nv.
  - Pulse dp_add_start, load counter = ADD_LAT-1, go to ADD.
  - UF from the multiply stage is intermediate and is not reported.
- ADD: exactly ADD_LAT cycles, then RADD.
- RADD (1 cycle): pulse dp_add_rnd_cap, sample the add flags, go to DONE.
- DONE:
  - out_valid=1.
  - out_fflags = {NV, 0, OF_m|OF_a, UF_a, NX_m|NX_a|OF_m}.
  - Outputs are held until out_ready.
  - On out_ready with no new accept, go to IDLE. On out_ready with an accept in the same cycle, go straight to MUL (or DONE if the new rm is illegal) with no bubble.
- Latency: out_valid first rises MUL_LAT+ADD_LAT+3 cycles after the accept edge (7 at defaults). Throughput is one op per MUL_LAT+ADD_LAT+3 cycles without stalls.
- flush: on the next edge go to IDLE, clear accumulated flags and out_illegal, and pulse nothing. flush has priority over out_ready and over a new accept in the same cycle; in_ready is forced to 0 while flush=1.
- rst asserted mid-operation immediately returns the FSM to reset values regardless of state.
- Flag accumulators are cleared on every accept.

Decomposition:
- Shared package fpu_ctrl_pkg holds:
  - state encoding (localparam constants, 3 bits);
  - rounding-mode constants RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100, DYN=111;
  - fflags bit indices.
- One natural sub-module, fpu_rm_resolve: combinational; computes rm_eff and legal from in_rm and frm_csr. It is reused by the other FPU op controllers.

Test Plan:
- Reset then single op, in_rm=000, dp_mul_sflags=001, dp_add_sflags=000, out_ready=1 -> dp_mul_start at accept, dp_mul_rnd_cap at +3, dp_add_start at +3, dp_add_rnd_cap at +6, out_valid at +7, out_fflags=00001.
- in_rm=111, frm_csr=011 -> dp_rm=011 throughout. With frm_csr=101 instead -> out_valid at +1, out_illegal=1, no dp_* pulses.
- out_ready held 0 for 5 cycles in DONE -> out_valid and out_fflags stable, in_ready=0. Then out_ready=1 together with in_valid=1 -> new dp_mul_start in the same cycle, busy stays 1.
- dp_mul_sflags=100 (overflow), dp_add_sflags=000, dp_nv=1 -> out_fflags=10101.
- flush asserted in ADD with in_valid=1 -> next cycle state IDLE, busy=0, no dp_add_rnd_cap, no accept. Repeat with rst pulsed asynchronously mid-MUL -> all outputs 0 and in_ready=1 immediately.
- MUL_LAT=1, ADD_LAT=3 build -> out_valid at accept+7, dp_add_rnd_cap at accept+6.
